// File: rtl/musicbox_pkg.sv
// Shared constants and types for the music-box tone path.
package musicbox_pkg;

    localparam int HALF_W = 19;
    localparam int ENV_W  = 8;

    // Octave-2 half-periods in 50 MHz clock cycles, C through B.
    localparam logic [HALF_W-1:0] BASE_HALF [12] = '{
        19'd382_228, 19'd360_771, 19'd340_526, 19'd321_411,
        19'd303_372, 19'd286_346, 19'd270_273, 19'd255_105,
        19'd240_788, 19'd227_273, 19'd214_516, 19'd202_478
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } tone_state_t;

endpackage

// File: rtl/onehot_dec.sv
// One-hot to binary index decoder with population classification.
module onehot_dec (
    input  logic [15:0] code,
    output logic [3:0]  idx,
    output logic        valid,
    output logic        zero,
    output logic        multi
);

    logic [4:0] ones;

    // Count set bits and remember the position of the (last) set bit.
    always_comb begin
        idx  = '0;
        ones = '0;
        for (int i = 0; i < 16; i++) begin
            if (code[i]) begin
                idx  = 4'(i);
                ones = ones + 5'd1;
            end
        end
        zero  = (ones == 5'd0);
        valid = (ones == 5'd1);
        multi = (ones > 5'd1);
    end

endmodule

// File: rtl/tone_gen.sv
// Square-wave tone generator with a decaying PWM envelope (music-box pluck).
module tone_gen
    import musicbox_pkg::*;
#(
    parameter int DECAY_CYCLES = 195_312,
    parameter int ENV_FLOOR    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] signal,
    input  logic [2:0]  band,
    input  logic        en,
    output logic        tone,
    output logic        audio,
    output logic        playing,
    output logic        note_err
);

    localparam int               PRE_W    = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DECAY_CYCLES - 1);
    localparam logic [ENV_W-1:0] ENV_MAX  = '1;
    localparam logic [ENV_W-1:0] ENV_MIN  = ENV_W'(ENV_FLOOR);

    logic [15:0]       sig_q, sig_prev;
    logic [2:0]        band_q, band_prev;
    logic              en_q;

    logic [3:0]        dec_idx;
    logic              dec_valid, dec_zero, dec_multi;
    logic              note_ok;
    logic              changed;

    logic [HALF_W-1:0] base_half, half, half_q, tcnt;
    logic [PRE_W-1:0]  pre;
    logic [ENV_W-1:0]  env;
    logic [7:0]        pwm_cnt;
    logic              tone_q;

    tone_state_t       state, state_d;
    logic              start;

    onehot_dec u_dec (
        .code  (sig_q),
        .idx   (dec_idx),
        .valid (dec_valid),
        .zero  (dec_zero),
        .multi (dec_multi)
    );

    // Register the reader's outputs and keep last cycle's copy for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q     <= '0;
            band_q    <= '0;
            en_q      <= 1'b0;
            sig_prev  <= '0;
            band_prev <= '0;
            note_err  <= 1'b0;
        end else begin
            sig_q     <= signal;
            band_q    <= band;
            en_q      <= en;
            sig_prev  <= sig_q;
            band_prev <= band_q;
            note_err  <= dec_multi;
        end
    end

    // Classify the sampled code and look up the octave-shifted half-period.
    always_comb begin
        note_ok   = dec_valid && !dec_zero && (dec_idx >= 4'd1) && (dec_idx <= 4'd12);
        changed   = (sig_q != sig_prev) || (band_q != band_prev);
        base_half = '0;
        for (int i = 0; i < 12; i++) begin
            if (dec_idx == 4'(i + 1)) base_half = BASE_HALF[i];
        end
        half = base_half >> band_q;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    // Next state and start-event detection (entry to PLAY or a note/band change while playing).
    always_comb begin
        state_d = state;
        start   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en_q && note_ok) begin
                    state_d = ST_PLAY;
                    start   = 1'b1;
                end
            end
            ST_PLAY: begin
                if (!en_q || !note_ok) state_d = ST_IDLE;
                else if (changed)      start   = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Tone phase and envelope; a start overrides any wrap on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt   <= '0;
            tone_q <= 1'b0;
            half_q <= '0;
            pre    <= '0;
            env    <= '0;
        end else if (start) begin
            tcnt   <= '0;
            tone_q <= 1'b0;
            half_q <= half;
            pre    <= '0;
            env    <= ENV_MAX;
        end else if (state == ST_PLAY && state_d == ST_PLAY) begin
            if (tcnt == half_q - HALF_W'(1)) begin
                tcnt   <= '0;
                tone_q <= ~tone_q;
            end else begin
                tcnt <= tcnt + HALF_W'(1);
            end
            if (pre == PRE_LAST) begin
                pre <= '0;
                if (env > ENV_MIN) env <= env - ENV_W'(1);
            end else begin
                pre <= pre + PRE_W'(1);
            end
        end else begin
            tcnt   <= '0;
            tone_q <= 1'b0;
        end
    end

    // Free-running PWM carrier for the envelope.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + 8'd1;
    end

    assign playing = (state == ST_PLAY);
    assign tone    = tone_q;
    assign audio   = playing && tone_q && (pwm_cnt < env);

endmodule

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen against a closed-form pluck model.
module tb_tone_gen;

    localparam int DECAY = 16;
    localparam int FLOOR = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] signal = '0;
    logic [2:0]  band = '0;
    logic        en = 1'b0;
    logic        tone, audio, playing, note_err;

    int errors = 0;
    int checks = 0;
    int cyc;

    int base_tbl [12] = '{382228, 360771, 340526, 321411, 303372, 286346,
                          270273, 255105, 240788, 227273, 214516, 202478};

    tone_gen #(.DECAY_CYCLES(DECAY), .ENV_FLOOR(FLOOR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .signal   (signal),
        .band     (band),
        .en       (en),
        .tone     (tone),
        .audio    (audio),
        .playing  (playing),
        .note_err (note_err)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the DUT's PWM carrier equals this modulo 256.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic int half_of(int n, int b);
        return base_tbl[n-1] >> b;
    endfunction

    function automatic logic [15:0] note_code(int n);
        logic [15:0] c;
        c    = '0;
        c[n] = 1'b1;
        return c;
    endfunction

    // {playing, tone, audio} k cycles after a start event, observed at cycle c.
    function automatic logic [2:0] expect_play(int k, int half, int c);
        logic t;
        int   e;
        t = ((k / half) % 2) == 1;
        e = 255 - k / DECAY;
        if (e < FLOOR) e = FLOOR;
        return {1'b1, t, t && ((c % 256) < e)};
    endfunction

    task automatic set_in(logic [15:0] s, logic [2:0] b, logic e);
        signal = s;
        band   = b;
        en     = e;
    endtask

    task automatic test_reset();
        int s;
        #2;
        checks++;
        if ({tone, audio, playing, note_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_init: got %b want 0000", {tone, audio, playing, note_err});
        end
        #10 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({playing, tone, audio, note_err} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle: got %b want 0000", {playing, tone, audio, note_err});
            end
        end
        set_in(note_code(10), 3'd7, 1'b1);
        s = cyc + 2;
        while (cyc - s < 1800) @(negedge clk);
        checks++;
        if ({playing, tone} !== 2'b11) begin
            errors++;
            $display("FAIL reset_prenote: got {playing,tone}=%b want 11", {playing, tone});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tone, audio, playing, note_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async: got %b want 0000", {tone, audio, playing, note_err});
        end
        set_in(16'h0000, 3'd0, 1'b0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({playing, tone, audio, note_err} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_after: got %b want 0000", {playing, tone, audio, note_err});
            end
        end
    endtask

    task automatic test_base_note();
        int s, half;
        logic [2:0] exp;
        half = half_of(10, 0);
        set_in(note_code(10), 3'd0, 1'b1);
        s = cyc + 2;
        @(negedge clk);
        checks++;
        if (playing !== 1'b0) begin
            errors++;
            $display("FAIL base_latency: playing=%b want 0", playing);
        end
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            exp = expect_play(cyc - s, half, cyc);
            checks++;
            if ({playing, tone, audio} !== exp) begin
                errors++;
                $display("FAIL base_note: k=%0d got %b want %b", cyc - s, {playing, tone, audio}, exp);
                break;
            end
        end
        set_in(16'h0000, 3'd0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_octave();
        int s, half;
        logic [2:0] exp;
        half = half_of(10, 3);
        set_in(note_code(10), 3'd3, 1'b1);
        s = cyc + 2;
        @(negedge clk);
        for (int i = 0; i <= half + 20; i++) begin
            @(negedge clk);
            exp = expect_play(cyc - s, half, cyc);
            checks++;
            if ({playing, tone, audio} !== exp) begin
                errors++;
                $display("FAIL octave3: k=%0d got %b want %b", cyc - s, {playing, tone, audio}, exp);
                break;
            end
        end
        band = 3'd4;
        @(negedge clk);
        exp = expect_play(cyc - s, half, cyc);
        checks++;
        if ({playing, tone, audio} !== exp) begin
            errors++;
            $display("FAIL octave_hold: got %b want %b", {playing, tone, audio}, exp);
        end
        s    = cyc + 1;
        half = half_of(10, 4);
        for (int i = 0; i <= half + 20; i++) begin
            @(negedge clk);
            exp = expect_play(cyc - s, half, cyc);
            checks++;
            if ({playing, tone, audio} !== exp) begin
                errors++;
                $display("FAIL octave4: k=%0d got %b want %b", cyc - s, {playing, tone, audio}, exp);
                break;
            end
        end
        set_in(16'h0000, 3'd0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_decay();
        int s, half, hi;
        logic [2:0] exp;
        half = half_of(12, 7);
        hi   = 0;
        set_in(note_code(12), 3'd7, 1'b1);
        s = cyc + 2;
        @(negedge clk);
        for (int i = 0; i < 6400; i++) begin
            @(negedge clk);
            exp = expect_play(cyc - s, half, cyc);
            checks++;
            if ({playing, tone, audio} !== exp) begin
                errors++;
                $display("FAIL decay: k=%0d got %b want %b", cyc - s, {playing, tone, audio}, exp);
                break;
            end
            if (cyc - s >= 3 * half && cyc - s < 3 * half + 256 && audio) hi++;
        end
        checks++;
        if (hi !== 32) begin
            errors++;
            $display("FAIL decay_duty: audio high %0d of 256 cycles, want 32", hi);
        end
        set_in(16'h0000, 3'd0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_stop_repluck();
        int n, half, s;
        logic [2:0] exp;
        n    = $urandom_range(1, 12);
        half = half_of(n, 7);
        set_in(note_code(n), 3'd7, 1'b1);
        s = cyc + 2;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            exp = expect_play(cyc - s, half, cyc);
            checks++;
            if ({playing, tone, audio} !== exp) begin
                errors++;
                $display("FAIL stop_pre: k=%0d got %b want %b", cyc - s, {playing, tone, audio}, exp);
                break;
            end
        end
        en = 1'b0;
        @(negedge clk);
        exp = expect_play(cyc - s, half, cyc);
        checks++;
        if ({playing, tone, audio} !== exp) begin
            errors++;
            $display("FAIL stop_hold: got %b want %b", {playing, tone, audio}, exp);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({playing, tone, audio} !== 3'b000) begin
                errors++;
                $display("FAIL stop_silent: got %b want 000", {playing, tone, audio});
            end
        end
        repeat (4) @(negedge clk);
        en = 1'b1;
        s  = cyc + 2;
        @(negedge clk);
        checks++;
        if (playing !== 1'b0) begin
            errors++;
            $display("FAIL repluck_latency: playing=%b want 0", playing);
        end
        for (int i = 0; i < half + 30; i++) begin
            @(negedge clk);
            exp = expect_play(cyc - s, half, cyc);
            checks++;
            if ({playing, tone, audio} !== exp) begin
                errors++;
                $display("FAIL repluck: k=%0d got %b want %b", cyc - s, {playing, tone, audio}, exp);
                break;
            end
        end
        signal = 16'h0000;
        @(negedge clk);
        exp = expect_play(cyc - s, half, cyc);
        checks++;
        if ({playing, tone, audio} !== exp) begin
            errors++;
            $display("FAIL gap_hold: got %b want %b", {playing, tone, audio}, exp);
        end
        signal = note_code(n);
        @(negedge clk);
        checks++;
        if ({playing, tone, audio} !== 3'b000) begin
            errors++;
            $display("FAIL gap_low: got %b want 000", {playing, tone, audio});
        end
        s = cyc + 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            exp = expect_play(cyc - s, half, cyc);
            checks++;
            if ({playing, tone, audio} !== exp) begin
                errors++;
                $display("FAIL gap_repluck: k=%0d got %b want %b", cyc - s, {playing, tone, audio}, exp);
                break;
            end
        end
        set_in(16'h0000, 3'd0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_invalid();
        int   t;
        logic exp_err;
        logic [15:0] codes [2];
        codes[0] = 16'h0006;
        codes[1] = 16'h0180;
        for (int c = 0; c < 2; c++) begin
            int hold;
            hold = (c == 0) ? 1 : 3;
            set_in(codes[c], 3'd7, 1'b1);
            t = cyc;
            for (int i = 1; i <= hold + 4; i++) begin
                @(negedge clk);
                exp_err = (i >= 2) && (i <= hold + 1);
                checks++;
                if ({note_err, playing, audio} !== {exp_err, 2'b00}) begin
                    errors++;
                    $display("FAIL multi_hot%0d: i=%0d got {err,playing,audio}=%b want %b",
                             hold, cyc - t, {note_err, playing, audio}, {exp_err, 2'b00});
                end
                if (i == hold) signal = 16'h0000;
            end
        end
        set_in(note_code(5), 3'd7, 1'b1);
        repeat (20) @(negedge clk);
        signal = 16'h0030;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (i == 1) begin
                if ({note_err, playing} !== 2'b01) begin
                    errors++;
                    $display("FAIL invalid_play_hold: got {err,playing}=%b want 01", {note_err, playing});
                end
            end else if ({note_err, playing, tone, audio} !== 4'b1000) begin
                errors++;
                $display("FAIL invalid_play_stop: i=%0d got %b want 1000", i, {note_err, playing, tone, audio});
            end
        end
        signal = 16'h0000;
        repeat (3) @(negedge clk);
        codes[0] = 16'h2000;
        codes[1] = 16'h0001;
        for (int c = 0; c < 2; c++) begin
            signal = codes[c];
            for (int i = 1; i <= 6; i++) begin
                @(negedge clk);
                checks++;
                if ({note_err, playing, tone, audio} !== 4'b0000) begin
                    errors++;
                    $display("FAIL reserved_%h: got %b want 0000", codes[c], {note_err, playing, tone, audio});
                end
            end
        end
        set_in(16'h0000, 3'd0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n, cur, half, s, len;
        logic [2:0] exp;
        cur  = 3;
        half = half_of(cur, 7);
        set_in(note_code(cur), 3'd7, 1'b1);
        s = cyc + 2;
        repeat (2) @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            if (r == 0)      len = half - 2 - (cyc - s);
            else if (r == 1) len = 16 + (16 - ((cyc - s + 2) % 16)) % 16;
            else             len = $urandom_range(0, 300);
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                exp = expect_play(cyc - s, half, cyc);
                checks++;
                if ({playing, tone, audio} !== exp) begin
                    errors++;
                    $display("FAIL b2b_hold: r=%0d k=%0d got %b want %b", r, cyc - s, {playing, tone, audio}, exp);
                    break;
                end
            end
            n = $urandom_range(1, 12);
            if (n == cur) n = (n % 12) + 1;
            signal = note_code(n);
            @(negedge clk);
            exp = expect_play(cyc - s, half, cyc);
            checks++;
            if ({playing, tone, audio} !== exp) begin
                errors++;
                $display("FAIL b2b_edge: r=%0d got %b want %b", r, {playing, tone, audio}, exp);
            end
            s    = cyc + 1;
            cur  = n;
            half = half_of(n, 7);
            for (int i = 0; i < half + 40; i++) begin
                @(negedge clk);
                exp = expect_play(cyc - s, half, cyc);
                checks++;
                if ({playing, tone, audio} !== exp) begin
                    errors++;
                    $display("FAIL b2b_note: r=%0d n=%0d k=%0d got %b want %b",
                             r, n, cyc - s, {playing, tone, audio}, exp);
                    break;
                end
            end
        end
        set_in(16'h0000, 3'd0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_base_note();
        test_octave();
        test_decay();
        test_stop_repluck();
        test_invalid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
